// File: rtl/melody_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | melody_sequencer_if : control/status bundle for the melody sequencer    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface melody_sequencer_if;
  logic        beat_clk;
  logic        play;
  logic        stop;
  logic [17:0] note_div;
  logic [4:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output beat_clk, play, stop,
    input  note_div, note_idx, busy, done
  );

  modport slave (
    input  beat_clk, play, stop,
    output note_div, note_idx, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | melody_sequencer : steps a fixed melody table on beat edges, inserting  |
// | a silent gap between notes. rev 1.0                                     |
// +-------------------------------------------------------------------------+
module melody_sequencer #(
  parameter int SONG_LEN = 14,
  parameter int GAP_CYC  = 2000000,
  parameter bit LOOP     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  melody_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0]  LAST_IDX = 5'(SONG_LEN - 1);
  localparam logic [20:0] GAP_LAST = 21'(GAP_CYC - 1);

  state_t      state;
  logic        beat_q;
  logic        beat_tick;
  logic [1:0]  beat_cnt;
  logic [20:0] gap_cnt;
  logic [17:0] note_div;
  logic [4:0]  note_idx;
  logic        busy;
  logic        done;

  function automatic logic [3:0] entry_code(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1, 5'd13:       entry_code = 4'd1;
      5'd2, 5'd3, 5'd6:        entry_code = 4'd5;
      5'd4, 5'd5:              entry_code = 4'd6;
      5'd7, 5'd8:              entry_code = 4'd4;
      5'd9, 5'd10:             entry_code = 4'd3;
      5'd11, 5'd12:            entry_code = 4'd2;
      default:                 entry_code = 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] entry_dur(input logic [4:0] idx);
    entry_dur = (idx == 5'd6 || idx == 5'd13) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [17:0] code_div(input logic [3:0] code);
    case (code)
      4'd1:    code_div = 18'd191113;
      4'd2:    code_div = 18'd170265;
      4'd3:    code_div = 18'd151686;
      4'd4:    code_div = 18'd143172;
      4'd5:    code_div = 18'd127551;
      4'd6:    code_div = 18'd113636;
      4'd7:    code_div = 18'd101239;
      4'd8:    code_div = 18'd95556;
      default: code_div = 18'd0;
    endcase
  endfunction

  // Either edge of the slow beat square wave yields one registered tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q    <= 1'b0;
      beat_tick <= 1'b0;
    end else begin
      beat_q    <= bus.beat_clk;
      beat_tick <= bus.beat_clk ^ beat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.stop) begin
      state    <= IDLE;
      note_div <= 18'd0;
      note_idx <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat_cnt <= 2'd0;
      gap_cnt  <= 21'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.play) begin
            state    <= PLAY;
            note_idx <= 5'd0;
            beat_cnt <= entry_dur(5'd0);
            note_div <= code_div(entry_code(5'd0));
            busy     <= 1'b1;
          end
        end
        PLAY: begin
          if (beat_tick) begin
            if (beat_cnt > 2'd1) begin
              beat_cnt <= beat_cnt - 2'd1;
            end else if (note_idx != LAST_IDX) begin
              note_idx <= note_idx + 5'd1;
              beat_cnt <= entry_dur(note_idx + 5'd1);
              note_div <= 18'd0;
              gap_cnt  <= 21'd0;
              state    <= GAP;
            end else if (LOOP) begin
              note_idx <= 5'd0;
              beat_cnt <= entry_dur(5'd0);
              note_div <= 18'd0;
              gap_cnt  <= 21'd0;
              state    <= GAP;
            end else begin
              beat_cnt <= 2'd0;
              note_div <= 18'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        GAP: begin
          // Ticks are deliberately ignored here; the note resumes on time.
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= 21'd0;
            note_div <= code_div(entry_code(note_idx));
            state    <= PLAY;
          end else begin
            gap_cnt <= gap_cnt + 21'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.note_div = note_div;
  assign bus.note_idx = note_idx;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_melody_sequencer : directed scoreboard bench, one-shot and looping   |
// | instances with a short gap. rev 1.0                                     |
// +-------------------------------------------------------------------------+
module tb_melody_sequencer;

  logic clk;
  logic rst_n;

  melody_sequencer_if ifa ();
  melody_sequencer_if ifb ();

  melody_sequencer #(.SONG_LEN(14), .GAP_CYC(4), .LOOP(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  melody_sequencer #(.SONG_LEN(14), .GAP_CYC(4), .LOOP(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sel;
    logic [17:0] div;
    logic [4:0]  idx;
    logic        busy;
    logic        done;
    bit          idx_dc;
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  int code_tab [14] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
  int dur_tab  [14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};
  int div_tab  [9]  = '{0, 191113, 170265, 151686, 143172, 127551, 113636, 101239, 95556};

  int m_idx  [2];
  int m_left [2];

  function automatic logic [17:0] exp_div(input int idx);
    return 18'(div_tab[code_tab[idx]]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input bit sel, input logic [17:0] div,
                      input int idx, input logic busy, input logic done, input bit idx_dc);
    sb_item_t e;
    e.tag = tag; e.sel = sel; e.div = div; e.idx = 5'(idx);
    e.busy = busy; e.done = done; e.idx_dc = idx_dc;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    sb_item_t    e;
    logic [17:0] d;
    logic [4:0]  i;
    logic        b;
    logic        dn;
    logic [24:0] obs;
    logic [24:0] exp;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      d = ifb.note_div; i = ifb.note_idx; b = ifb.busy; dn = ifb.done;
    end else begin
      d = ifa.note_div; i = ifa.note_idx; b = ifa.busy; dn = ifa.done;
    end
    obs = {d, (e.idx_dc ? 5'd0 : i), b, dn};
    exp = {e.div, (e.idx_dc ? 5'd0 : e.idx), e.busy, e.done};
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d observed div=%0d idx=%0d busy=%b done=%b expected div=%0d idx=%0d busy=%b done=%b",
             e.tag, e.sel, d, i, b, dn, e.div, e.idx, e.busy, e.done);
    end
  endtask

  task automatic toggle_beat(input bit sel);
    if (sel) ifb.beat_clk = ~ifb.beat_clk;
    else     ifa.beat_clk = ~ifa.beat_clk;
  endtask

  task automatic start(input bit sel);
    if (sel) ifb.play = 1'b1; else ifa.play = 1'b1;
    push("play_start", sel, 18'd191113, 0, 1'b1, 1'b0, 1'b0);
    step();
    pop_check();
    ifa.play = 1'b0;
    ifb.play = 1'b0;
    m_idx[sel]  = 0;
    m_left[sel] = dur_tab[0];
  endtask

  task automatic run_gap(input bit sel, input bit tick_in_gap);
    for (int k = 0; k < 4; k++) begin
      push("gap_silent", sel, 18'd0, m_idx[sel], 1'b1, 1'b0, 1'b0);
      step();
      pop_check();
      if (k == 0 && tick_in_gap) toggle_beat(sel);
    end
    push("gap_resume", sel, exp_div(m_idx[sel]), m_idx[sel], 1'b1, 1'b0, 1'b0);
    step();
    pop_check();
  endtask

  task automatic beat(input bit sel, input bit tick_in_gap);
    toggle_beat(sel);
    push("tick_latency", sel, exp_div(m_idx[sel]), m_idx[sel], 1'b1, 1'b0, 1'b0);
    step();
    pop_check();
    if (m_left[sel] > 1) begin
      m_left[sel]--;
      push("beat_hold", sel, exp_div(m_idx[sel]), m_idx[sel], 1'b1, 1'b0, 1'b0);
      step();
      pop_check();
    end else if (m_idx[sel] < 13) begin
      m_idx[sel]++;
      m_left[sel] = dur_tab[m_idx[sel]];
      run_gap(sel, tick_in_gap);
    end else if (sel) begin
      m_idx[sel]  = 0;
      m_left[sel] = dur_tab[0];
      run_gap(sel, tick_in_gap);
    end else begin
      push("done_pulse", sel, 18'd0, 13, 1'b0, 1'b1, 1'b0);
      step();
      pop_check();
      push("after_done", sel, 18'd0, 0, 1'b0, 1'b0, 1'b1);
      step();
      pop_check();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.beat_clk = 1'b0; ifa.play = 1'b0; ifa.stop = 1'b0;
    ifb.beat_clk = 1'b0; ifb.play = 1'b0; ifb.stop = 1'b0;
    repeat (2) step();
    push("reset_a", 1'b0, 18'd0, 0, 1'b0, 1'b0, 1'b0); pop_check();
    push("reset_b", 1'b1, 18'd0, 0, 1'b0, 1'b0, 1'b0); pop_check();
    rst_n = 1'b1;
    step();

    // Full one-shot melody with a busy play pulse and a tick inside a gap.
    start(1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    ifa.play = 1'b1;
    push("play_while_busy", 1'b0, exp_div(m_idx[0]), m_idx[0], 1'b1, 1'b0, 1'b0);
    step();
    pop_check();
    ifa.play = 1'b0;
    beat(1'b0, 1'b1);
    repeat (3) beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    push("g_still_entry6", 1'b0, 18'd127551, 6, 1'b1, 1'b0, 1'b0); pop_check();
    beat(1'b0, 1'b0);
    push("f_entry7", 1'b0, 18'd143172, 7, 1'b1, 1'b0, 1'b0); pop_check();
    repeat (8) beat(1'b0, 1'b0);
    step();
    push("idle_after_done", 1'b0, 18'd0, 0, 1'b0, 1'b0, 1'b1); step(); pop_check();

    // Stop arriving in the same cycle as a tick during entry 3.
    start(1'b0);
    repeat (3) beat(1'b0, 1'b0);
    toggle_beat(1'b0);
    push("tick_latency_e3", 1'b0, exp_div(3), 3, 1'b1, 1'b0, 1'b0);
    step();
    pop_check();
    ifa.stop = 1'b1;
    push("stop_with_tick", 1'b0, 18'd0, 0, 1'b0, 1'b0, 1'b0);
    step();
    pop_check();
    ifa.stop = 1'b0;
    push("idle_after_stop", 1'b0, 18'd0, 0, 1'b0, 1'b0, 1'b0);
    step();
    pop_check();
    ifa.play = 1'b1;
    ifa.stop = 1'b1;
    push("play_and_stop", 1'b0, 18'd0, 0, 1'b0, 1'b0, 1'b0);
    step();
    pop_check();
    ifa.play = 1'b0;
    ifa.stop = 1'b0;

    // Reset in the middle of entry 5, then a clean restart.
    start(1'b0);
    repeat (5) beat(1'b0, 1'b0);
    push("at_entry5", 1'b0, 18'd113636, 5, 1'b1, 1'b0, 1'b0); pop_check();
    rst_n = 1'b0;
    push("mid_reset", 1'b0, 18'd0, 0, 1'b0, 1'b0, 1'b0);
    step();
    pop_check();
    rst_n = 1'b1;
    start(1'b0);

    // Looping instance wraps to entry 0 without a done pulse.
    start(1'b1);
    repeat (16) beat(1'b1, 1'b0);
    push("loop_wrapped", 1'b1, 18'd191113, 0, 1'b1, 1'b0, 1'b0); pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
